// File: rtl/l2_pkg.sv
// rtl/l2_pkg.sv - shared types, constants and helpers for the L2 next-line prefetcher
package l2_pkg;

  localparam int ADDR_W      = 32;
  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } pf_state_t;

  typedef logic [LINE_BITS-1:0] line_t;

  // Clear the byte-offset bits so an address points at the start of its line.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/l2_next_line_prefetcher_if.sv
// rtl/l2_next_line_prefetcher_if.sv - L2 / physical-memory bus seen by the prefetcher
interface l2_next_line_prefetcher_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BITS  = 256,
  parameter int CNT_WIDTH  = 16
);

  logic                  enable;
  logic                  miss_valid;
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic                  prefetch;
  logic                  prefetch_ready;
  logic                  prefetch_busy;
  logic [ADDR_WIDTH-1:0] pf_addr;
  logic [LINE_BITS-1:0]  pf_line;
  logic                  pf_pmem_read;
  logic [ADDR_WIDTH-1:0] pf_pmem_address;
  logic [LINE_BITS-1:0]  pmem_rdata;
  logic                  pmem_resp;
  logic [CNT_WIDTH-1:0]  pf_issued;
  logic [CNT_WIDTH-1:0]  pf_used;

  // Prefetcher side: it issues the pmem reads and serves lines to L2.
  modport master (
    input  enable, miss_valid, miss_addr, prefetch, pmem_rdata, pmem_resp,
    output prefetch_ready, prefetch_busy, pf_addr, pf_line,
           pf_pmem_read, pf_pmem_address, pf_issued, pf_used
  );

  // L2 controller and physical memory side.
  modport slave (
    output enable, miss_valid, miss_addr, prefetch, pmem_rdata, pmem_resp,
    input  prefetch_ready, prefetch_busy, pf_addr, pf_line,
           pf_pmem_read, pf_pmem_address, pf_issued, pf_used
  );

endinterface

// File: rtl/pf_sat_counter.sv
// rtl/pf_sat_counter.sv - saturating event counter for prefetch statistics
module pf_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;

  // Count events, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && !(&count_q)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/l2_next_line_prefetcher.sv
// rtl/l2_next_line_prefetcher.sv - next-line prefetcher with a one-entry line buffer
module l2_next_line_prefetcher #(
  parameter int ADDR_WIDTH  = l2_pkg::ADDR_W,
  parameter int LINE_BITS   = l2_pkg::LINE_BITS,
  parameter int OFFSET_BITS = l2_pkg::OFFSET_BITS,
  parameter int CNT_WIDTH   = l2_pkg::CNT_W
) (
  input logic                   clk,
  input logic                   reset,
  l2_next_line_prefetcher_if.master bus
);

  import l2_pkg::pf_state_t;
  import l2_pkg::IDLE;
  import l2_pkg::FETCH;
  import l2_pkg::FULL;

  localparam int LINE_NUM_W = ADDR_WIDTH - OFFSET_BITS;

  pf_state_t              state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pf_addr_q, pf_addr_d;
  logic [LINE_BITS-1:0]   pf_line_q, pf_line_d;
  logic                   issue_inc;
  logic                   use_inc;

  logic [LINE_NUM_W-1:0]  miss_line;
  logic [LINE_NUM_W-1:0]  next_line;
  logic                   has_cand;
  logic                   start_fetch;
  logic [ADDR_WIDTH-1:0]  next_addr;

  // The last line of memory has no successor: the increment would wrap to line 0.
  assign miss_line   = bus.miss_addr[ADDR_WIDTH-1:OFFSET_BITS];
  assign next_line   = miss_line + 1'b1;
  assign has_cand    = ~&miss_line;
  assign next_addr   = {next_line, {OFFSET_BITS{1'b0}}};
  assign start_fetch = bus.miss_valid && bus.enable && has_cand;

  // State, address and line buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pf_addr_q <= '0;
      pf_line_q <= '0;
    end else begin
      state_q   <= state_d;
      pf_addr_q <= pf_addr_d;
      pf_line_q <= pf_line_d;
    end
  end

  // Next-state logic; in FULL a consume beats a concurrent miss.
  always_comb begin
    state_d   = state_q;
    pf_addr_d = pf_addr_q;
    pf_line_d = pf_line_q;
    issue_inc = 1'b0;
    use_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_fetch) begin
          pf_addr_d = next_addr;
          issue_inc = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (bus.pmem_resp) begin
          pf_line_d = bus.pmem_rdata;
          state_d   = FULL;
        end
      end
      FULL: begin
        if (bus.prefetch) begin
          use_inc = 1'b1;
          state_d = IDLE;
        end else if (start_fetch) begin
          pf_addr_d = next_addr;
          issue_inc = 1'b1;
          state_d   = FETCH;
        end else if (bus.miss_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  pf_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_issued_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (issue_inc),
    .count (bus.pf_issued)
  );

  pf_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_used_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (use_inc),
    .count (bus.pf_used)
  );

  assign bus.prefetch_busy   = (state_q == FETCH);
  assign bus.pf_pmem_read    = (state_q == FETCH);
  assign bus.prefetch_ready  = (state_q == FULL);
  assign bus.pf_addr         = pf_addr_q;
  assign bus.pf_pmem_address = pf_addr_q;
  assign bus.pf_line         = pf_line_q;

endmodule

// File: tb/tb_l2_next_line_prefetcher.sv
// tb/tb_l2_next_line_prefetcher.sv - directed self-checking bench for l2_next_line_prefetcher
module tb_l2_next_line_prefetcher;

  logic clk;
  logic reset;

  int n_total;
  int n_pass;

  logic [255:0] line_a5;
  logic [255:0] line_11;
  logic [255:0] line_22;
  logic [255:0] line_33;

  l2_next_line_prefetcher_if #(.ADDR_WIDTH(32), .LINE_BITS(256), .CNT_WIDTH(16)) pf1 ();
  l2_next_line_prefetcher_if #(.ADDR_WIDTH(32), .LINE_BITS(256), .CNT_WIDTH(2))  pf2 ();

  l2_next_line_prefetcher dut (
    .clk   (clk),
    .reset (reset),
    .bus   (pf1.master)
  );

  l2_next_line_prefetcher #(.CNT_WIDTH(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (pf2.master)
  );

  assign pf2.enable     = pf1.enable;
  assign pf2.miss_valid = pf1.miss_valid;
  assign pf2.miss_addr  = pf1.miss_addr;
  assign pf2.prefetch   = pf1.prefetch;
  assign pf2.pmem_rdata = pf1.pmem_rdata;
  assign pf2.pmem_resp  = pf1.pmem_resp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic miss(input logic [31:0] addr);
    pf1.miss_valid = 1'b1;
    pf1.miss_addr  = addr;
    tick();
    pf1.miss_valid = 1'b0;
  endtask

  task automatic respond(input logic [255:0] data);
    pf1.pmem_resp  = 1'b1;
    pf1.pmem_rdata = data;
    tick();
    pf1.pmem_resp  = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    line_a5 = {32{8'hA5}};
    line_11 = {32{8'h11}};
    line_22 = {32{8'h22}};
    line_33 = {32{8'h33}};

    reset          = 1'b1;
    pf1.enable     = 1'b0;
    pf1.miss_valid = 1'b0;
    pf1.miss_addr  = '0;
    pf1.prefetch   = 1'b0;
    pf1.pmem_rdata = '0;
    pf1.pmem_resp  = 1'b0;
    tick();
    tick();

    chk("rst_ready",  pf1.prefetch_ready, 0);
    chk("rst_busy",   pf1.prefetch_busy, 0);
    chk("rst_read",   pf1.pf_pmem_read, 0);
    chk("rst_addr",   pf1.pf_addr, 0);
    chk("rst_line",   pf1.pf_line, 0);
    chk("rst_issued", pf1.pf_issued, 0);
    chk("rst_used",   pf1.pf_used, 0);
    reset = 1'b0;
    tick();

    // Miss at 0x1044 fetches the following line 0x1060.
    pf1.enable = 1'b1;
    miss(32'h0000_1044);
    chk("t1_read",   pf1.pf_pmem_read, 1);
    chk("t1_maddr",  pf1.pf_pmem_address, 32'h0000_1060);
    chk("t1_busy",   pf1.prefetch_busy, 1);
    chk("t1_issued", pf1.pf_issued, 1);
    chk("t1_ready",  pf1.prefetch_ready, 0);

    // Response after 5 cycles, then L2 consumes the line.
    for (int i = 0; i < 4; i++) tick();
    chk("t2_read_hold", pf1.pf_pmem_read, 1);
    respond(line_a5);
    chk("t2_ready", pf1.prefetch_ready, 1);
    chk("t2_line",  pf1.pf_line, line_a5);
    chk("t2_read",  pf1.pf_pmem_read, 0);
    chk("t2_busy",  pf1.prefetch_busy, 0);
    tick();
    tick();
    chk("t2_hold_ready", pf1.prefetch_ready, 1);
    chk("t2_hold_addr",  pf1.pf_addr, 32'h0000_1060);
    pf1.prefetch = 1'b1;
    tick();
    pf1.prefetch = 1'b0;
    chk("t2_consumed", pf1.prefetch_ready, 0);
    chk("t2_used",     pf1.pf_used, 1);

    // Last line of memory has no successor.
    miss(32'hFFFF_FFE8);
    chk("t3_read",   pf1.pf_pmem_read, 0);
    chk("t3_ready",  pf1.prefetch_ready, 0);
    chk("t3_issued", pf1.pf_issued, 1);

    // A new miss while FULL replaces the buffered line.
    miss(32'h0000_1044);
    respond(line_11);
    chk("t4_full_addr", pf1.pf_addr, 32'h0000_1060);
    miss(32'h0000_2000);
    chk("t4_read",   pf1.pf_pmem_read, 1);
    chk("t4_maddr",  pf1.pf_pmem_address, 32'h0000_2020);
    chk("t4_issued", pf1.pf_issued, 3);
    chk("t4_used",   pf1.pf_used, 1);
    chk("t4_ready",  pf1.prefetch_ready, 0);
    respond(line_22);
    chk("t4_line", pf1.pf_line, line_22);
    pf1.prefetch   = 1'b1;
    pf1.miss_valid = 1'b1;
    pf1.miss_addr  = 32'h0000_3000;
    tick();
    pf1.prefetch   = 1'b0;
    pf1.miss_valid = 1'b0;
    chk("t4_both_ready",  pf1.prefetch_ready, 0);
    chk("t4_both_read",   pf1.pf_pmem_read, 0);
    chk("t4_both_used",   pf1.pf_used, 2);
    chk("t4_both_issued", pf1.pf_issued, 3);

    // FETCH ignores enable drop, prefetch and miss; FULL + miss with enable low drops the line.
    miss(32'h0000_1044);
    pf1.enable     = 1'b0;
    pf1.prefetch   = 1'b1;
    pf1.miss_valid = 1'b1;
    pf1.miss_addr  = 32'h0000_5000;
    tick();
    pf1.prefetch   = 1'b0;
    pf1.miss_valid = 1'b0;
    chk("t4b_read",   pf1.pf_pmem_read, 1);
    chk("t4b_maddr",  pf1.pf_pmem_address, 32'h0000_1060);
    chk("t4b_issued", pf1.pf_issued, 4);
    chk("t4b_used",   pf1.pf_used, 2);
    respond(line_33);
    chk("t4b_ready", pf1.prefetch_ready, 1);
    miss(32'h0000_4000);
    chk("t4b_drop_ready",  pf1.prefetch_ready, 0);
    chk("t4b_drop_read",   pf1.pf_pmem_read, 0);
    chk("t4b_drop_issued", pf1.pf_issued, 4);

    // Reset mid-fetch, then a stale response arrives.
    pf1.enable = 1'b1;
    miss(32'h0000_1044);
    chk("t5_fetching", pf1.pf_pmem_read, 1);
    reset = 1'b1;
    #1;
    chk("t5_async_read",   pf1.pf_pmem_read, 0);
    chk("t5_async_busy",   pf1.prefetch_busy, 0);
    chk("t5_async_issued", pf1.pf_issued, 0);
    chk("t5_async_addr",   pf1.pf_addr, 0);
    pf1.pmem_resp  = 1'b1;
    pf1.pmem_rdata = line_a5;
    tick();
    reset = 1'b0;
    tick();
    pf1.pmem_resp = 1'b0;
    chk("t5_stale_ready", pf1.prefetch_ready, 0);
    chk("t5_stale_line",  pf1.pf_line, 0);
    chk("t5_stale_read",  pf1.pf_pmem_read, 0);

    // Disabled misses never fetch.
    pf1.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      miss(32'h0000_1044);
      chk("t6_disabled_read", pf1.pf_pmem_read, 0);
    end
    chk("t6_disabled_issued", pf1.pf_issued, 0);

    // Four full prefetch cycles: wide counters reach 4, 2-bit counters hold at 3.
    pf1.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      miss(32'h0000_1044);
      respond(line_11);
      pf1.prefetch = 1'b1;
      tick();
      pf1.prefetch = 1'b0;
    end
    chk("t6_issued_wide", pf1.pf_issued, 4);
    chk("t6_used_wide",   pf1.pf_used, 4);
    chk("t6_issued_sat",  pf2.pf_issued, 3);
    chk("t6_used_sat",    pf2.pf_used, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
